// File: rtl/instruction_fetch_responder_pkg.sv
// Shared definitions for the ARM fetch responder: state encoding, NOP word,
// default timeout and the registered response bundle.
package arm_fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fetch_state_e;

  localparam logic [31:0] ARM_NOP         = 32'hE1A00000;
  localparam int          DEFAULT_TIMEOUT = 16;

  // Response towards IF/ID; the pulse fields are cleared every cycle.
  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        align_err;
    logic        timeout_err;
  } fetch_rsp_t;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

  function automatic int count_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/instruction_fetch_responder_counter.sv
// Wait-cycle counter for an outstanding fetch; flags the last permitted
// cycle before the fetch is abandoned.
module fetch_timeout_counter
  import arm_fetch_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = count_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  // Clear wins over enable so a new fetch always starts from zero.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign terminal = (count_reg == LAST);

endmodule

// File: rtl/instruction_fetch_responder.sv
// IF-stage fetch responder: turns the PC into a req/ack memory transaction,
// freezes the PC while waiting, and reports misalignment, flush and timeout.
module instruction_fetch_responder
  import arm_fetch_pkg::*;
#(
  parameter int          TIMEOUT  = DEFAULT_TIMEOUT,
  parameter logic [31:0] NOP_WORD = ARM_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        freeze_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        align_err,
  output logic        timeout_err
);

  fetch_state_e state_reg;
  fetch_state_e state_next;
  logic         discard_reg;
  logic         discard_next;
  logic [31:0]  mem_addr_reg;
  logic [31:0]  mem_addr_next;
  fetch_rsp_t   rsp_reg;
  fetch_rsp_t   rsp_next;

  logic cnt_clear;
  logic cnt_enable;
  logic cnt_terminal;
  logic drop_data;
  logic freeze_raw;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  // A flush in the completing cycle kills the data just like an earlier one.
  assign drop_data = discard_reg | flush;

  always_comb begin
    state_next    = state_reg;
    discard_next  = discard_reg;
    mem_addr_next = mem_addr_reg;
    rsp_next      = '0;
    rsp_next.instr = rsp_reg.instr;
    cnt_clear     = 1'b0;
    cnt_enable    = 1'b0;
    freeze_raw    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (fetch_en) begin
          if (is_word_aligned(pc_in[1:0])) begin
            mem_addr_next = {pc_in[31:2], 2'b00};
            discard_next  = 1'b0;
            cnt_clear     = 1'b1;
            freeze_raw    = 1'b1;
            state_next    = BUSY;
          end else begin
            rsp_next.instr     = NOP_WORD;
            rsp_next.valid     = 1'b1;
            rsp_next.align_err = 1'b1;
          end
        end
      end

      BUSY: begin
        if (mem_ack) begin
          // Ack takes priority over a coincident timeout.
          state_next = IDLE;
          if (!drop_data) begin
            rsp_next.instr = mem_rdata;
            rsp_next.valid = 1'b1;
          end
        end else if (cnt_terminal) begin
          state_next           = IDLE;
          rsp_next.timeout_err = 1'b1;
          if (!drop_data) begin
            rsp_next.instr = NOP_WORD;
            rsp_next.valid = 1'b1;
          end
        end else begin
          cnt_enable = 1'b1;
          freeze_raw = 1'b1;
          if (flush) begin
            discard_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      discard_reg  <= 1'b0;
      mem_addr_reg <= '0;
      rsp_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      discard_reg  <= discard_next;
      mem_addr_reg <= mem_addr_next;
      rsp_reg      <= rsp_next;
    end
  end

  // The branch target must always reach the PC, so flush overrides freeze.
  assign freeze_out  = freeze_raw & ~flush;
  assign mem_req     = (state_reg == BUSY);
  assign mem_addr    = mem_addr_reg;
  assign instr_out   = rsp_reg.instr;
  assign instr_valid = rsp_reg.valid;
  assign align_err   = rsp_reg.align_err;
  assign timeout_err = rsp_reg.timeout_err;

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Directed and randomized checks of instruction_fetch_responder against a
// transaction-level model of fetch outcome and per-cycle freeze/request.
module tb_instruction_fetch_responder;

  localparam int          TO  = 4;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        fetch_en;
  logic        flush;
  logic        freeze_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        align_err;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch_responder #(
    .TIMEOUT  (TO),
    .NOP_WORD (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .freeze_out  (freeze_out),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .align_err   (align_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One aligned fetch. lat = BUSY cycles before the ack (>= TO means none),
  // flush_at = BUSY cycle carrying flush (-1 for none).
  task automatic do_fetch(input logic [31:0] pc, input int lat, input int flush_at,
                          input logic [31:0] rdata, input string tag);
    int  end_k;
    bit  acked;
    bit  dropped;
    acked   = (lat < TO);
    end_k   = acked ? lat : TO - 1;
    dropped = (flush_at >= 0) && (flush_at <= end_k);
    pc_in = pc; fetch_en = 1'b1; flush = 1'b0; mem_ack = 1'b0;
    #1;
    chk({tag, " freeze_latch"}, freeze_out, 1'b1);
    chk({tag, " req_idle"}, mem_req, 1'b0);
    tick();
    fetch_en = 1'b0;
    for (int k = 0; k <= end_k; k++) begin
      chk({tag, " req_busy"}, mem_req, 1'b1);
      chk({tag, " addr"}, mem_addr, pc);
      mem_ack   = (k == lat);
      mem_rdata = (k == lat) ? rdata : 32'h0BAD_0000 | 32'(k);
      flush     = (k == flush_at);
      #1;
      chk({tag, " freeze_busy"}, freeze_out, (k != end_k) && (k != flush_at));
      tick();
      mem_ack = 1'b0;
      flush   = 1'b0;
    end
    chk({tag, " req_done"}, mem_req, 1'b0);
    chk({tag, " valid"}, instr_valid, !dropped);
    chk({tag, " timeout"}, timeout_err, !acked);
    chk({tag, " align"}, align_err, 1'b0);
    if (!dropped) chk({tag, " instr"}, instr_out, acked ? rdata : NOP);
    $display("[TB] %s pc=%h lat=%0d flush_at=%0d valid=%0b instr=%h", tag, pc, lat,
             flush_at, instr_valid, instr_out);
    tick();
    chk({tag, " valid_pulse"}, instr_valid, 1'b0);
  endtask

  task automatic do_misaligned(input logic [31:0] pc, input string tag);
    pc_in = pc; fetch_en = 1'b1; flush = 1'b0; mem_ack = 1'b0;
    #1;
    chk({tag, " freeze"}, freeze_out, 1'b0);
    tick();
    fetch_en = 1'b0;
    chk({tag, " req"}, mem_req, 1'b0);
    chk({tag, " valid"}, instr_valid, 1'b1);
    chk({tag, " instr"}, instr_out, NOP);
    chk({tag, " align"}, align_err, 1'b1);
    $display("[TB] %s pc=%h align_err=%0b instr=%h", tag, pc, align_err, instr_out);
    tick();
    chk({tag, " align_pulse"}, align_err, 1'b0);
    chk({tag, " valid_pulse"}, instr_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] data [3];
    rst = 1'b0; pc_in = '0; fetch_en = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Reset
    tick(); tick();
    chk("rst mem_req", mem_req, 1'b0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst instr_out", instr_out, 32'h0);
    chk("rst instr_valid", instr_valid, 1'b0);
    chk("rst freeze", freeze_out, 1'b0);
    chk("rst errs", {align_err, timeout_err}, 2'b00);
    rst = 1'b1;
    tick();
    $display("[TB] reset released");

    // Basic fetch and flush mid-fetch (ack on the last allowed cycle)
    do_fetch(32'h10, 2, -1, 32'hE3A01005, "basic");
    do_fetch(32'h20, 3, 1, 32'hDEADBEEF, "flush");
    do_fetch(32'h100, 0, -1, 32'hE1A01002, "after_flush");

    // Misaligned PC
    do_misaligned(32'h6, "misalign");

    // Timeout, then a late ack that must be ignored
    do_fetch(32'h40, TO + 5, -1, 32'h0, "timeout");
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    chk("late_ack valid", instr_valid, 1'b0);
    chk("late_ack req", mem_req, 1'b0);
    chk("late_ack instr", instr_out, NOP);
    $display("[TB] late_ack valid=%0b", instr_valid);

    // Reset mid-fetch
    pc_in = 32'h80; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    chk("rst_mid req_busy", mem_req, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_mid req", mem_req, 1'b0);
    chk("rst_mid valid", instr_valid, 1'b0);
    chk("rst_mid instr", instr_out, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    chk("rst_mid ack_valid", instr_valid, 1'b0);
    chk("rst_mid ack_instr", instr_out, 32'h0);
    $display("[TB] rst_mid valid=%0b instr=%h", instr_valid, instr_out);

    // Back-to-back fetches with immediate ack
    data[0] = 32'hE3A00001; data[1] = 32'hE3A00002; data[2] = 32'hE3A00003;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'(4 * i); fetch_en = 1'b1;
      #1;
      chk("b2b freeze_latch", freeze_out, 1'b1);
      chk("b2b valid_idle", instr_valid, i > 0);
      if (i > 0) chk("b2b instr", instr_out, data[i-1]);
      tick();
      chk("b2b addr", mem_addr, 32'(4 * i));
      chk("b2b valid_busy", instr_valid, 1'b0);
      mem_ack = 1'b1; mem_rdata = data[i];
      #1;
      chk("b2b freeze_ack", freeze_out, 1'b0);
      tick();
      mem_ack = 1'b0;
      $display("[TB] b2b pc=%h valid=%0b instr=%h", 32'(4 * i), instr_valid, instr_out);
    end
    fetch_en = 1'b0;
    chk("b2b last_valid", instr_valid, 1'b1);
    chk("b2b last_instr", instr_out, data[2]);
    tick();

    // Randomized fetches
    for (int n = 0; n < 40; n++) begin
      logic [31:0] pc;
      int lat, fa, end_k;
      pc = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        if (pc[1:0] == 2'b00) pc[0] = 1'b1;
        do_misaligned(pc, "rnd_mis");
      end else begin
        pc[1:0] = 2'b00;
        lat   = $urandom_range(0, TO + 1);
        end_k = (lat < TO) ? lat : TO - 1;
        fa    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, end_k)) : -1;
        do_fetch(pc, lat, fa, $urandom, "rnd");
      end
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_responder.md
Name: instruction_fetch_responder

Overview:
Fetch-side counterpart to the PC register in the IF stage. It consumes the PC value, runs a request/acknowledge transaction to instruction memory, and returns the fetched word to the IF/ID register. It drives the PC register's freeze input, holding the PC until the current fetch completes or is flushed. It also handles branch flush mid-fetch, misaligned PCs and memory timeouts.

Parameters:
TIMEOUT, 16, BUSY cycles without mem_ack before the fetch is aborted (must be >= 2)
NOP_WORD, 32'hE1A00000, word returned on timeout or misalignment (MOV r0,r0)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
pc_in  input  32  current PC register output
fetch_en  input  1  IF stage wants an instruction this cycle
flush  input  1  branch taken; PC register loads target this cycle
freeze_out  output  1  to PC register freeze; high = hold PC
mem_req  output  1  memory request, high for the whole transaction
mem_addr  output  32  word-aligned fetch address, stable while mem_req
mem_rdata  input  32  memory read data, valid with mem_ack
mem_ack  input  1  memory completion, single-cycle pulse
instr_out  output  32  fetched instruction to IF/ID
instr_valid  output  1  one-cycle pulse, instr_out valid
align_err  output  1  one-cycle pulse, misaligned PC
timeout_err  output  1  one-cycle pulse, fetch aborted on timeout

Behaviour:
- Reset: rst==0 at posedge -> state IDLE, discard=0, count=0, instr_out=0, instr_valid=0, align_err=0, timeout_err=0, mem_addr=0. mem_req drops on the same edge. Reset mid-transaction abandons the fetch. A later mem_ack is ignored.
- States: IDLE, BUSY. mem_req = (state==BUSY), registered.
- IDLE, fetch_en=1, pc_in[1:0]==0: latch mem_addr=pc_in, count=0, discard=0, go to BUSY. freeze_out=1 this cycle.
- IDLE, fetch_en=1, pc_in[1:0]!=0: no request is issued. Next cycle instr_out=NOP_WORD, instr_valid=1, align_err=1. freeze_out=0 this cycle. State stays IDLE.
- IDLE, fetch_en=0: freeze_out=0, nothing happens.
- BUSY, no ack: count++. freeze_out=1.
- BUSY, mem_ack=1, discard=0, flush=0: instr_out<=mem_rdata, instr_valid<=1 next cycle, go to IDLE. freeze_out=0 in the ack cycle so the PC advances.
- BUSY, mem_ack=1, discard=1 or flush=1: data is dropped, instr_valid stays 0, go to IDLE.
- BUSY, flush=1 without ack: set discard=1 and remain BUSY. Memory cannot abort, so the bench waits for the ack.
- Timeout: count==TIMEOUT-1 with no ack -> go to IDLE, mem_req falls. If discard==0, instr_out=NOP_WORD, instr_valid=1, timeout_err=1. If discard==1, only timeout_err pulses. freeze_out=0 that cycle.
- mem_ack and timeout in the same cycle: ack wins, timeout_err=0.
- freeze_out is combinational and forced to 0 whenever flush=1, so the branch target always loads into the PC.
- mem_ack outside BUSY is ignored.
- Minimum throughput: one instruction per 2 cycles (IDLE latch, then BUSY with immediate ack).
- Fetch latency from fetch_en to instr_valid: memory latency + 2 cycles.
- count width: clog2(TIMEOUT). No wrap, because it resets on every new fetch.

Decomposition:
- Package arm_fetch_pkg holds the state encoding (IDLE=1'b0, BUSY=1'b1), the ARM NOP constant and the default TIMEOUT.
- One sub-module is natural: fetch_timeout_counter (clear, enable, terminal-count output).

Test Plan:
1. Reset then basic fetch: rst=0 for 2 cycles, then pc_in=0x00000010, fetch_en=1, mem_ack 3 cycles after mem_req with rdata=0xE3A01005. Expect mem_addr=0x10, freeze_out high until the ack cycle, then instr_valid=1 and instr_out=0xE3A01005.
2. Flush mid-fetch: BUSY on pc=0x20, flush=1 at BUSY cycle 1, ack at cycle 4 with rdata=0xDEADBEEF. Expect freeze_out=0 during the flush, no instr_valid, and the next fetch on the new pc_in=0x100.
3. Misaligned PC: pc_in=0x00000006, fetch_en=1. Expect mem_req to stay 0, then instr_valid=1, instr_out=0xE1A00000 and align_err=1 for one cycle.
4. Timeout: TIMEOUT=4, no ack. Expect mem_req high for 4 cycles, then instr_out=0xE1A00000 and timeout_err=1. A late ack 2 cycles later is ignored.
5. Reset mid-fetch: rst=0 during BUSY. Expect mem_req=0 next cycle and instr_valid=0. A subsequent ack produces no output.
6. Back-to-back fetches: fetch_en held high with an immediate ack, pc 0x0,0x4,0x8. Expect instr_valid every second cycle with the correct data order.
